alu_cmd_sequencer: RTL and testbench
====================================

Name: alu_cmd_sequencer

Overview:
- Sits between the SPI slave frame output and the shared 4-bit ALU.
- Buffers incoming 10-bit command frames in a small FIFO and issues them to the ALU one at a time.
- Waits a programmable settle latency, then captures result and flags into holding registers that drive the PWM and BCD display.
- Presents each {flags, result} byte to the SPI response loader with a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 4, command FIFO entries (power of two, ≥2).
- ALU_LAT, 1, clock edges from operand load to result capture (≥1).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- frame_bits  in  10  SPI frame: [9:6]=a, [5:2]=b, [1:0]=sel.
- frame_valid  in  1  one-cycle strobe, already synchronised to clk; frame_bits stable while high.
- clr_err  in  1  clears overrun sticky flag.
- alu_result  in  4  ALU Result.
- alu_flags  in  4  ALU {N,Z,C,V}.
- resp_ready  in  1  response loader accepts resp_data.
- alu_a  out  4  registered operand a.
- alu_b  out  4  registered operand b.
- alu_sel  out  2  registered opcode.
- result_q  out  4  last captured result (to PWM/BCD).
- flags_q  out  4  last captured {N,Z,C,V}.
- resp_data  out  8  {flags_q, result_q}.
- resp_valid  out  1  response pending.
- busy  out  1  high whenever state ≠ IDLE.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overrun  out  1  sticky: a frame was dropped because the FIFO was full.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All outputs 0; FIFO emptied (pointers and count 0); state IDLE; latency counter 0.
  - Takes effect immediately mid-operation. Any in-flight command and pending response are discarded.
- FIFO push:
  - On an edge with frame_valid=1 and FIFO not full, frame_bits is written at the tail.
  - If the FIFO is full, the frame is dropped and overrun is set to 1.
  - Push and pop on the same edge are both honoured; the count is unchanged.
  - A push into a full FIFO coinciding with a pop is accepted, since the pop frees a slot that edge.
- Overrun flag: clr_err=1 clears it on the next edge. If a set and clr_err happen on the same edge, set wins.
- Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, WAIT, RESP.
  - IDLE, fifo_count>0: on the edge, the head is popped; alu_a/alu_b/alu_sel are loaded from head fields; counter=0; next state WAIT.
  - IDLE, empty: hold. alu_* keep their last values.
  - WAIT: counter increments each edge. On the edge where counter==ALU_LAT-1:
    - result_q ← alu_result and flags_q ← alu_flags;
    - resp_valid ← 1;
    - next state RESP.
  - RESP: resp_valid held high and resp_data held stable until resp_ready is sampled high. On that edge resp_valid ← 0 and next state IDLE.
  - resp_ready while resp_valid=0 is ignored.
- Operands are frozen during WAIT and RESP. The FIFO keeps accepting pushes in every state.
- Latency: frame_valid sampled at edge E into an empty FIFO in IDLE gives operand load at E+1 and resp_valid high after E+1+ALU_LAT. One command takes at least ALU_LAT+2 cycles (load, wait, one RESP cycle with resp_ready already high).
- result_q and flags_q change only at capture; between commands they hold the last values.

Test Plan:
- Single command, ALU_LAT=1:
  - Stimulus: frame_bits=0x0D4 (a=3, b=5, sel=0) strobed at edge 0; bench ALU model drives result=8, flags=4'b1001; resp_ready=1.
  - Required: alu_a=3, alu_b=5, alu_sel=0 after edge 1; resp_valid=1 and resp_data=0x98 after edge 2; resp_valid=0 after edge 3; busy=0 after edge 3.
- Backpressure:
  - Stimulus: resp_ready=0 for 10 cycles after resp_valid rises.
  - Required: resp_valid and resp_data stay stable; next FIFO entry not popped; fifo_count unchanged apart from new pushes; completion on the first edge resp_ready=1.
- Overrun:
  - Stimulus: resp_ready=0; strobe 6 frames (0x001..0x006), FIFO_DEPTH=4.
  - Required: first frame in flight, 4 buffered; 6th dropped; overrun=1, fifo_count=4.
  - Then: clr_err clears overrun; releasing resp_ready yields responses in order for frames 1–5 only.
- Simultaneous push/pop:
  - Stimulus: frame_valid on the same edge IDLE pops with fifo_count=1.
  - Required: fifo_count stays 1; new frame issued next.
- Reset mid-WAIT, ALU_LAT=3:
  - Stimulus: assert rst_n=0 between clock edges while in WAIT with 2 entries queued.
  - Required: all outputs 0 immediately (before the next edge), fifo_count=0, no response after release.
- Wrap-around:
  - Stimulus: 10 sequential frames with resp_ready=1, spaced so the FIFO never fills.
  - Required: responses in exact issue order, pointers wrap twice, no overrun.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: buffers SPI command frames and sequences them one at a time through the shared ALU
module alu_cmd_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int ALU_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic [9:0] frame_bits,
    input  logic frame_valid,
    input  logic clr_err,
    input  logic [3:0] alu_result,
    input  logic [3:0] alu_flags,
    input  logic resp_ready,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_sel,
    output logic [3:0] result_q,
    output logic [3:0] flags_q,
    output logic [7:0] resp_data,
    output logic resp_valid,
    output logic busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic overrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(ALU_LAT) + 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic [9:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] lat_cnt;
    logic pop, push, full, capture;
    assign full = fifo_count == (AW+1)'(FIFO_DEPTH);
    assign pop = state == IDLE && fifo_count != '0;
    assign push = frame_valid && (!full || pop);
    assign capture = state == WAIT && lat_cnt == LW'(ALU_LAT - 1);
    assign busy = state != IDLE;
    assign resp_valid = state == RESP;
    assign resp_data = {flags_q, result_q};
    // Frame storage; slots are only read after being written, so no reset is needed
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= frame_bits;
    // FIFO pointers, occupancy and sticky overrun (a new drop beats a simultaneous clear)
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fifo_count <= '0;
            overrun <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
            overrun <= (frame_valid && !push) ? 1'b1 : clr_err ? 1'b0 : overrun;
        end
    // Sequencer state register
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    // Next state: issue when idle with work queued, respond after the settle time, retire on handshake
    always_comb begin
        state_nx = state;
        state_nx = pop ? WAIT : capture ? RESP : (resp_valid && resp_ready) ? IDLE : state;
    end
    // Operand load on issue, settle counter, and result/flag capture
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            alu_a <= '0;
            alu_b <= '0;
            alu_sel <= '0;
            lat_cnt <= '0;
            result_q <= '0;
            flags_q <= '0;
        end else begin
            if (pop) begin
                {alu_a, alu_b, alu_sel} <= mem[rd_ptr];
                lat_cnt <= '0;
            end else if (state == WAIT) lat_cnt <= lat_cnt + 1'b1;
            if (capture) begin
                result_q <= alu_result;
                flags_q <= alu_flags;
            end
        end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: randomized and directed checks of alu_cmd_sequencer against a transaction-level model
module tb_alu_cmd_sequencer;
    localparam int DEPTH = 4;
    localparam int LAT = 1;
    logic clk = 0;
    logic rst_n = 0, rst3_n = 0;
    logic [9:0] frame_bits = 0, fb3 = 0;
    logic frame_valid = 0, fv3 = 0, clr_err = 0, clr3 = 0, resp_ready = 0, rr3 = 0;
    logic [3:0] alu_result, alu_flags, alu_a, alu_b, result_q, flags_q;
    logic [1:0] alu_sel;
    logic [7:0] resp_data, alu_out;
    logic resp_valid, busy, overrun;
    logic [2:0] fifo_count;
    logic [3:0] a3, b3, r3, f3, res3, flg3;
    logic [1:0] s3;
    logic [7:0] d3, alu_out3;
    logic v3, busy3, ovr3;
    logic [2:0] cnt3;
    int checks = 0, failures = 0;
    bit chk_on = 0;
    logic [7:0] got[$];
    logic [9:0] sent[10];
    logic [9:0] m_q[$];
    logic [9:0] m_cmd = 0;
    logic [7:0] m_out = 0;
    bit m_act = 0, m_resp = 0, m_ovr = 0;
    int m_left = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [9:0] f);
        logic [3:0] a, b, r;
        logic [4:0] s;
        logic c, v;
        a = f[9:6];
        b = f[5:2];
        s = (f[1:0] == 2'd0) ? {1'b0, a} + {1'b0, b} : {1'b0, a} - {1'b0, b};
        c = 0;
        v = 0;
        case (f[1:0])
            2'd0: begin r = s[3:0]; c = s[4]; v = (a[3] == b[3]) && (r[3] != a[3]); end
            2'd1: begin r = s[3:0]; c = s[4]; v = (a[3] != b[3]) && (r[3] != a[3]); end
            2'd2: r = a & b;
            default: r = a ^ b;
        endcase
        return {r[3], r == 4'd0, c, v, r};
    endfunction

    assign alu_out = alu_fn({alu_a, alu_b, alu_sel});
    assign alu_result = alu_out[3:0];
    assign alu_flags = alu_out[7:4];
    assign alu_out3 = alu_fn({a3, b3, s3});
    assign res3 = alu_out3[3:0];
    assign flg3 = alu_out3[7:4];

    alu_cmd_sequencer #(.FIFO_DEPTH(DEPTH), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .frame_bits(frame_bits), .frame_valid(frame_valid),
        .clr_err(clr_err), .alu_result(alu_result), .alu_flags(alu_flags), .resp_ready(resp_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .result_q(result_q), .flags_q(flags_q),
        .resp_data(resp_data), .resp_valid(resp_valid), .busy(busy), .fifo_count(fifo_count),
        .overrun(overrun));

    alu_cmd_sequencer #(.FIFO_DEPTH(4), .ALU_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst3_n), .frame_bits(fb3), .frame_valid(fv3),
        .clr_err(clr3), .alu_result(res3), .alu_flags(flg3), .resp_ready(rr3),
        .alu_a(a3), .alu_b(b3), .alu_sel(s3), .result_q(r3), .flags_q(f3),
        .resp_data(d3), .resp_valid(v3), .busy(busy3), .fifo_count(cnt3),
        .overrun(ovr3));

    task automatic cmp(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input string n);
        for (int i = 0; i < 60 && (busy || fifo_count != 0); i++) tick();
        cmp(n, int'(busy || fifo_count != 0), 0);
    endtask

    // Transaction-level reference: a queue of frames, one command in flight with a countdown, one pending response
    always @(posedge clk or negedge rst_n) begin : model
        bit pop, full;
        if (!rst_n) begin
            m_q.delete();
            m_cmd = 0;
            m_out = 0;
            m_act = 0;
            m_resp = 0;
            m_ovr = 0;
            m_left = 0;
        end else begin
            pop = !m_act && m_q.size() != 0;
            full = m_q.size() == DEPTH;
            if (m_act && !m_resp) begin
                m_left--;
                if (m_left == 0) begin
                    m_out = alu_fn(m_cmd);
                    m_resp = 1;
                end
            end else if (m_resp && resp_ready) begin
                m_resp = 0;
                m_act = 0;
            end
            if (pop) begin
                m_cmd = m_q.pop_front();
                m_act = 1;
                m_left = LAT;
            end
            if (frame_valid && (!full || pop)) m_q.push_back(frame_bits);
            m_ovr = (frame_valid && full && !pop) ? 1'b1 : clr_err ? 1'b0 : m_ovr;
        end
    end

    always @(negedge clk) if (chk_on) begin
        cmp("alu_a", alu_a, m_cmd[9:6]);
        cmp("alu_b", alu_b, m_cmd[5:2]);
        cmp("alu_sel", alu_sel, m_cmd[1:0]);
        cmp("result_q", result_q, m_out[3:0]);
        cmp("flags_q", flags_q, m_out[7:4]);
        cmp("resp_data", resp_data, m_out);
        cmp("resp_valid", resp_valid, m_resp);
        cmp("busy", busy, m_act);
        cmp("fifo_count", fifo_count, m_q.size());
        cmp("overrun", overrun, m_ovr);
        if (resp_valid && resp_ready) got.push_back(resp_data);
    end

    initial begin
        logic [7:0] d;
        repeat (2) tick();
        cmp("reset_main", {alu_a, alu_b, alu_sel, result_q, flags_q, resp_data, resp_valid, busy, fifo_count, overrun}, 0);
        cmp("reset_lat3", {a3, b3, s3, r3, f3, d3, v3, busy3, cnt3, ovr3}, 0);
        rst_n = 1;
        rst3_n = 1;
        chk_on = 1;
        tick();
        // single command: 3+5 add -> result 8, flags N..V = 1001
        frame_bits = 10'h0D4; frame_valid = 1; resp_ready = 1;
        tick();
        frame_valid = 0;
        tick();
        cmp("single_a", alu_a, 3);
        cmp("single_b", alu_b, 5);
        cmp("single_sel", alu_sel, 0);
        tick();
        cmp("single_valid", resp_valid, 1);
        cmp("single_data", resp_data, 8'h98);
        tick();
        cmp("single_done", resp_valid, 0);
        cmp("single_idle", busy, 0);
        // backpressure: 10 & 9 = 8 -> 0x88 held while resp_ready is low
        resp_ready = 0; frame_bits = 10'h2A6; frame_valid = 1;
        tick();
        frame_valid = 0;
        for (int i = 0; i < 10 && !resp_valid; i++) tick();
        cmp("bp_rise", resp_valid, 1);
        d = resp_data;
        cmp("bp_data", d, 8'h88);
        frame_bits = 10'h1C7; frame_valid = 1;
        tick();
        frame_valid = 0;
        repeat (9) tick();
        cmp("bp_hold_valid", resp_valid, 1);
        cmp("bp_hold_data", resp_data, d);
        cmp("bp_no_pop", fifo_count, 1);
        resp_ready = 1;
        tick();
        cmp("bp_release", resp_valid, 0);
        cmp("bp_queued", fifo_count, 1);
        drain("bp_drain");
        // overrun: 6 frames into a depth-4 FIFO with the first one in flight
        got.delete();
        resp_ready = 0;
        for (int i = 1; i <= 6; i++) begin
            frame_bits = 10'(i); frame_valid = 1; clr_err = (i == 6);
            tick();
            if (i == 2) cmp("push_pop_count", fifo_count, 1);
        end
        frame_valid = 0; clr_err = 0;
        cmp("ovr_set_wins", overrun, 1);
        cmp("ovr_count", fifo_count, 4);
        clr_err = 1;
        tick();
        clr_err = 0;
        cmp("ovr_clear", overrun, 0);
        resp_ready = 1;
        drain("ovr_drain");
        cmp("ovr_resp_n", got.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < got.size()) cmp("ovr_order", got[i], alu_fn(10'(i + 1)));
        // wrap-around: 10 spaced frames, FIFO never fills
        got.delete();
        for (int i = 0; i < 10; i++) begin
            sent[i] = 10'($urandom);
            frame_bits = sent[i]; frame_valid = 1;
            tick();
            frame_valid = 0;
            repeat (3) tick();
        end
        drain("wrap_drain");
        cmp("wrap_resp_n", got.size(), 10);
        for (int i = 0; i < 10; i++)
            if (i < got.size()) cmp("wrap_order", got[i], alu_fn(sent[i]));
        cmp("wrap_no_ovr", overrun, 0);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            frame_valid = $urandom_range(0, 2) == 0;
            frame_bits = 10'($urandom);
            resp_ready = $urandom_range(0, 3) != 0;
            clr_err = $urandom_range(0, 15) == 0;
            tick();
        end
        frame_valid = 0; resp_ready = 1; clr_err = 0;
        drain("rand_drain");
        // ALU_LAT=3 instance: asynchronous reset while waiting with two frames queued
        rr3 = 0; fb3 = 10'h3D5; fv3 = 1;
        tick();
        fb3 = 10'h2C4;
        tick();
        fb3 = 10'h1B0;
        tick();
        fv3 = 0;
        cmp("l3_busy", busy3, 1);
        cmp("l3_queued", cnt3, 2);
        cmp("l3_waiting", v3, 0);
        cmp("l3_a", a3, 15);
        #3 rst3_n = 0;
        #1 cmp("l3_async_reset", {a3, b3, s3, r3, f3, d3, v3, busy3, cnt3, ovr3}, 0);
        tick();
        rst3_n = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            cmp("l3_no_resp", v3, 0);
        end
        cmp("l3_idle", {busy3, cnt3}, 0);
        // ALU_LAT=3 latency: load at E+1, response at E+4
        fb3 = 10'h0D4; fv3 = 1; rr3 = 1;
        tick();
        fv3 = 0;
        tick();
        cmp("l3_load", a3, 3);
        repeat (2) tick();
        cmp("l3_not_yet", v3, 0);
        tick();
        cmp("l3_valid", v3, 1);
        cmp("l3_data", d3, 8'h98);
        tick();
        cmp("l3_done", v3, 0);
        chk_on = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
